// File: rtl/fp_to_linear.sv
`default_nettype none
// ============================================================================
// Module  : fp_to_linear
// Purpose : Expands an (S, E, F) float word to a DW-bit two's-complement value,
//           shifting one bit per cycle. Ready/valid handshakes on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module fp_to_linear #(
  parameter int FW = 4,
  parameter int EW = 3,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          S,
  input  logic [EW-1:0] E,
  input  logic [FW-1:0] F,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] D,
  output logic          busy
);

  localparam logic [DW-1:0] c_d_one   = DW'(1);
  localparam logic [EW-1:0] c_cnt_one = EW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_mag;
  logic [EW-1:0] r_cnt;
  logic          r_sign;
  logic [DW-1:0] r_d;
  logic          r_out_valid;

  // Readiness depends only on registered state, never on in_valid.
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign D         = r_d;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mag       <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_d         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign  <= S;
            r_cnt   <= E;
            r_mag   <= {{(DW-FW){1'b0}}, F};
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt - c_cnt_one;
          end else begin
            // Negating a zero magnitude yields zero, so no negative zero exists.
            r_d         <= r_sign ? (~r_mag + c_d_one) : r_mag;
            r_out_valid <= 1'b1;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_to_linear.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_to_linear
// Purpose : Directed self-checking bench for fp_to_linear.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp_to_linear;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        s_in;
  logic [2:0]  e_in;
  logic [3:0]  f_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] d_out;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  fp_to_linear #(.FW(4), .EW(3), .DW(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (s_in),
    .E         (e_in),
    .F         (f_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one word, measure latency to out_valid, check D, then drain.
  task automatic run(input string tag, input logic s, input logic [2:0] e,
                     input logic [3:0] f, input logic [11:0] exp_d);
    int n;
    @(negedge clk);
    s_in = s; e_in = e; f_in = f; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Inputs after the accepting edge must not matter.
    s_in = ~s; e_in = ~e; f_in = ~f;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(e) + 32'd1);
    check({tag, "_d"}, 32'(d_out), 32'(exp_d));
    @(posedge clk); #1;
    check({tag, "_drained"}, {30'd0, out_valid, busy}, 32'd0);
    check({tag, "_d_held"}, 32'(d_out), 32'(exp_d));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    s_in = 1'b0; e_in = '0; f_in = '0;
    #2;
    check("reset_outputs", {19'd0, in_ready, out_valid, busy, d_out}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_ready", 32'(in_ready), 32'd1);

    run("t1_e0",   1'b0, 3'd0, 4'd1,  12'h001);
    run("t2_pos",  1'b0, 3'd2, 4'd11, 12'h02C);
    run("t2_neg",  1'b1, 3'd2, 4'd11, 12'hFD4);
    run("t3_nmax", 1'b1, 3'd7, 4'd15, 12'h880);
    run("t3_pmax", 1'b0, 3'd7, 4'd15, 12'h780);
    run("t4_nz",   1'b1, 3'd3, 4'd0,  12'h000);
    run("t4_pz",   1'b0, 3'd5, 4'd0,  12'h000);

    // Backpressure: S=0,E=1,F=9 -> 18, consumer stalls 5 cycles
    @(negedge clk);
    s_in = 1'b0; e_in = 3'd1; f_in = 4'd9; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    s_in = 1'b1; e_in = 3'd0; f_in = 4'd3;  // competing word held valid
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
    end
    check("t5_valid_arrived", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t5_hold", {19'd0, out_valid, in_ready, busy, d_out}, {19'd0, 3'b101, 12'h012});
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t5_release", {19'd0, out_valid, in_ready, busy, d_out}, {19'd0, 3'b010, 12'h012});

    // Asynchronous reset in the middle of a long shift
    @(negedge clk);
    s_in = 1'b0; e_in = 3'd6; f_in = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    check("t6_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_async_reset", {19'd0, out_valid, in_ready, busy, d_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_ready_after", 32'(in_ready), 32'd1);
    run("t6_fresh", 1'b0, 3'd4, 4'd13, 12'h0D0);

    // out_ready outside OUT is ignored
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t7_idle_ready", {30'd0, busy, out_valid}, 32'd0);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
